// File: rtl/load_store_unit_if.sv
// Core/memory-side bus bundle for the load/store unit.
// master: the core and data_memory side; slave: the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        misaligned_err;
  logic        funct3_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  stall, rsp_valid, rsp_rdata, misaligned_err, funct3_err,
           mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output stall, rsp_valid, rsp_rdata, misaligned_err, funct3_err,
           mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns RISC-V byte/half/word accesses into word accesses
// on a memory without byte enables. Sub-word stores merge into the word read
// in the same cycle; word-crossing accesses take two cycles (one stall).
module load_store_unit #(
  parameter bit MISALIGNED_EN = 1'b1
) (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_lo;
  logic [31:0] w_lo_nxt;

  logic [1:0]  w_off;
  logic [2:0]  w_nbytes;
  logic        w_legal;
  logic        w_cross;
  logic [4:0]  w_shamt;
  logic [5:0]  w_hi_shamt;
  logic [31:0] w_a;
  logic [31:0] w_a4;
  logic [63:0] w_wide;
  logic [7:0]  w_mask8;

  logic        w_stall;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_rdata;
  logic        w_misaligned_err;
  logic        w_funct3_err;
  logic [31:0] w_mem_addr;
  logic [31:0] w_mem_wdata;
  logic        w_mem_we;

  // Truncate to the access size and sign/zero extend according to funct3.
  function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] f3);
    logic [31:0] r;
    r = 32'd0;
    case (f3)
      3'b000:  r = {{24{d[7]}}, d[7:0]};
      3'b001:  r = {{16{d[15]}}, d[15:0]};
      3'b010:  r = d;
      3'b100:  r = {24'd0, d[7:0]};
      3'b101:  r = {16'd0, d[15:0]};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Replace the bytes of old_w selected by be with the bytes of new_w.
  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        r[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        r[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return r;
  endfunction

  assign w_off      = bus.req_addr[1:0];
  assign w_a        = {bus.req_addr[31:2], 2'b00};
  assign w_a4       = w_a + 32'd4;
  assign w_shamt    = {w_off, 3'b000};
  assign w_hi_shamt = 6'd32 - {1'b0, w_shamt};
  // Store data and byte mask laid out across the two-word window starting at A.
  assign w_wide     = {32'd0, bus.req_wdata} << w_shamt;
  assign w_mask8    = ((8'd1 << w_nbytes) - 8'd1) << w_off;
  assign w_cross    = ({2'b00, w_off} + {1'b0, w_nbytes}) > 4'd4;

  // Decode access size and funct3 legality for loads and stores.
  always_comb begin
    w_nbytes = 3'd0;
    w_legal  = 1'b0;
    case (bus.req_funct3[1:0])
      2'b00:   w_nbytes = 3'd1;
      2'b01:   w_nbytes = 3'd2;
      2'b10:   w_nbytes = 3'd4;
      default: w_nbytes = 3'd0;
    endcase
    if (bus.req_we) begin
      w_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                (bus.req_funct3 == 3'b010);
    end else begin
      w_legal = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                (bus.req_funct3 == 3'b101);
    end
  end

  // Next-state logic and all combinational outputs; reset forces quiet outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_lo_nxt         = r_lo;
    w_stall          = 1'b0;
    w_rsp_valid      = 1'b0;
    w_rsp_rdata      = 32'd0;
    w_misaligned_err = 1'b0;
    w_funct3_err     = 1'b0;
    w_mem_addr       = w_a;
    w_mem_wdata      = 32'd0;
    w_mem_we         = 1'b0;
    if (rst) begin
      w_state_nxt = ST_IDLE;
      w_lo_nxt    = 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!bus.req_valid) begin
            w_state_nxt = ST_IDLE;
          end else if (!w_legal) begin
            w_funct3_err = 1'b1;
            w_rsp_valid  = 1'b1;
          end else if (!w_cross) begin
            w_rsp_valid = 1'b1;
            if (bus.req_we) begin
              w_mem_we    = 1'b1;
              w_mem_wdata = merge(bus.mem_rdata, w_wide[31:0], w_mask8[3:0]);
            end else begin
              w_rsp_rdata = extend(bus.mem_rdata >> w_shamt, bus.req_funct3);
            end
          end else if (!MISALIGNED_EN) begin
            w_misaligned_err = 1'b1;
            w_rsp_valid      = 1'b1;
          end else begin
            // First half of a word-crossing access: hold the core one cycle.
            w_stall     = 1'b1;
            w_state_nxt = ST_SECOND;
            if (bus.req_we) begin
              w_mem_we    = 1'b1;
              w_mem_wdata = merge(bus.mem_rdata, w_wide[31:0], w_mask8[3:0]);
            end else begin
              w_lo_nxt = bus.mem_rdata >> w_shamt;
            end
          end
        end
        ST_SECOND: begin
          // Second half targets the next word; a dropped request aborts it.
          w_mem_addr  = w_a4;
          w_state_nxt = ST_IDLE;
          if (bus.req_valid) begin
            w_rsp_valid = 1'b1;
            if (bus.req_we) begin
              w_mem_we    = 1'b1;
              w_mem_wdata = merge(bus.mem_rdata, w_wide[63:32], w_mask8[7:4]);
            end else begin
              w_rsp_rdata = extend(r_lo | (bus.mem_rdata << w_hi_shamt), bus.req_funct3);
            end
          end else begin
            w_rsp_valid = 1'b0;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State and low-half load register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

  assign bus.stall          = w_stall;
  assign bus.rsp_valid      = w_rsp_valid;
  assign bus.rsp_rdata      = w_rsp_rdata;
  assign bus.misaligned_err = w_misaligned_err;
  assign bus.funct3_err     = w_funct3_err;
  assign bus.mem_addr       = w_mem_addr;
  assign bus.mem_wdata      = w_mem_wdata;
  assign bus.mem_we         = w_mem_we;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: two instances (split enabled and
// disabled) share one word memory model; expected responses and memory writes
// are queued by the stimulus and checked by an independent monitor.
module tb_load_store_unit;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if bus_en ();
  load_store_unit_if bus_dis ();

  load_store_unit #(.MISALIGNED_EN(1'b1)) dut_en  (.clk(clk), .rst(rst), .bus(bus_en));
  load_store_unit #(.MISALIGNED_EN(1'b0)) dut_dis (.clk(clk), .rst(rst), .bus(bus_dis));

  logic        s_we;
  logic [2:0]  s_f3;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic        v_en;
  logic        v_dis;

  assign bus_en.req_valid   = v_en;
  assign bus_en.req_we      = s_we;
  assign bus_en.req_funct3  = s_f3;
  assign bus_en.req_addr    = s_addr;
  assign bus_en.req_wdata   = s_wdata;
  assign bus_dis.req_valid  = v_dis;
  assign bus_dis.req_we     = s_we;
  assign bus_dis.req_funct3 = s_f3;
  assign bus_dis.req_addr   = s_addr;
  assign bus_dis.req_wdata  = s_wdata;

  // 64-word memory, combinational read, write on rising edge
  logic [31:0] mem [64];
  assign bus_en.mem_rdata  = mem[bus_en.mem_addr[7:2]];
  assign bus_dis.mem_rdata = mem[bus_dis.mem_addr[7:2]];

  always @(posedge clk) begin
    if (bus_en.mem_we)  mem[bus_en.mem_addr[7:2]]  <= bus_en.mem_wdata;
    if (bus_dis.mem_we) mem[bus_dis.mem_addr[7:2]] <= bus_dis.mem_wdata;
  end

  // scoreboard queues
  logic [33:0] rsp_q [$];   // {funct3_err, misaligned_err, rsp_rdata}
  logic [63:0] wr_q  [$];   // {mem_addr, mem_wdata}
  string       nq    [$];   // direct checks: name, actual, expected
  logic [31:0] aq    [$];
  logic [31:0] eq    [$];

  int checks;
  int failures;

  initial begin
    checks   = 0;
    failures = 0;
  end

  // monitor: compares presented responses/writes and queued direct checks
  always @(negedge clk) begin
    logic [33:0] got_r;
    logic [33:0] exp_r;
    logic [63:0] got_w;
    logic [63:0] exp_w;
    string       n;
    logic [31:0] a;
    logic [31:0] e;
    if (bus_en.rsp_valid || bus_dis.rsp_valid) begin
      got_r = bus_en.rsp_valid ?
              {bus_en.funct3_err, bus_en.misaligned_err, bus_en.rsp_rdata} :
              {bus_dis.funct3_err, bus_dis.misaligned_err, bus_dis.rsp_rdata};
      checks++;
      if (rsp_q.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected actual=%h required=none", got_r);
      end else begin
        exp_r = rsp_q.pop_front();
        if (got_r !== exp_r) begin
          failures++;
          $display("FAIL rsp {ferr,merr,rdata} actual=%h required=%h", got_r, exp_r);
        end
      end
    end
    if (bus_en.mem_we || bus_dis.mem_we) begin
      got_w = bus_en.mem_we ? {bus_en.mem_addr, bus_en.mem_wdata} :
                              {bus_dis.mem_addr, bus_dis.mem_wdata};
      checks++;
      if (wr_q.size() == 0) begin
        failures++;
        $display("FAIL write_unexpected actual=%h required=none", got_w);
      end else begin
        exp_w = wr_q.pop_front();
        if (got_w !== exp_w) begin
          failures++;
          $display("FAIL write {addr,data} actual=%h required=%h", got_w, exp_w);
        end
      end
    end
    while (nq.size() > 0) begin
      n = nq.pop_front();
      a = aq.pop_front();
      e = eq.pop_front();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s actual=%h required=%h", n, a, e);
      end
    end
  end

  task automatic expect_eq(input string n, input logic [31:0] a, input logic [31:0] e);
    nq.push_back(n);
    aq.push_back(a);
    eq.push_back(e);
  endtask

  // drive one request and hold it until stall drops (bounded)
  task automatic issue(input bit dis, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input bit chk_addr, input logic [31:0] exp_addr, input int exp_stalls);
    int   stalls;
    bit   done;
    logic st;
    s_we = we; s_f3 = f3; s_addr = addr; s_wdata = wd;
    v_en = !dis; v_dis = dis;
    stalls = 0;
    done   = 1'b0;
    for (int k = 0; k < 4 && !done; k++) begin
      @(negedge clk);
      st = dis ? bus_dis.stall : bus_en.stall;
      if (k == 0 && chk_addr)
        expect_eq("mem_addr_first", dis ? bus_dis.mem_addr : bus_en.mem_addr, exp_addr);
      if (st) stalls++;
      else done = 1'b1;
      @(posedge clk); #1;
    end
    v_en = 1'b0; v_dis = 1'b0;
    expect_eq("completed", {31'd0, done}, 32'd1);
    expect_eq("stall_cycles", stalls, exp_stalls);
  endtask

  task automatic ld(input bit dis, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] exp_rd, input int exp_stalls);
    rsp_q.push_back({2'b00, exp_rd});
    issue(dis, 1'b0, f3, addr, 32'd0, 1'b1, {addr[31:2], 2'b00}, exp_stalls);
  endtask

  task automatic st_one(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] wword);
    wr_q.push_back({addr[31:2], 2'b00, wword});
    rsp_q.push_back(34'd0);
    issue(1'b0, 1'b1, f3, addr, wd, 1'b1, {addr[31:2], 2'b00}, 0);
  endtask

  task automatic st_two(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] w0, input logic [31:0] a1, input logic [31:0] w1);
    wr_q.push_back({addr[31:2], 2'b00, w0});
    wr_q.push_back({a1, w1});
    rsp_q.push_back(34'd0);
    issue(1'b0, 1'b1, f3, addr, wd, 1'b1, {addr[31:2], 2'b00}, 1);
  endtask

  task automatic err(input bit dis, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic merr, input logic ferr);
    rsp_q.push_back({ferr, merr, 32'd0});
    issue(dis, we, f3, addr, 32'hFFFF_FFFF, 1'b0, 32'd0, 0);
  endtask

  // crossing SW whose second half is cut by reset or by dropping req_valid
  task automatic cross_sw_cut(input bit use_rst, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] w0);
    wr_q.push_back({addr[31:2], 2'b00, w0});
    s_we = 1'b1; s_f3 = 3'b010; s_addr = addr; s_wdata = wd; v_en = 1'b1;
    @(negedge clk);
    expect_eq("cut_stall_first", {31'd0, bus_en.stall}, 32'd1);
    @(posedge clk); #1;
    if (use_rst) rst = 1'b1;
    else v_en = 1'b0;
    @(negedge clk);
    expect_eq("cut_stall_second", {31'd0, bus_en.stall}, 32'd0);
    expect_eq("cut_mem_we", {31'd0, bus_en.mem_we}, 32'd0);
    expect_eq("cut_rsp_valid", {31'd0, bus_en.rsp_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; v_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    v_en = 1'b0; v_dis = 1'b0;
    s_we = 1'b0; s_f3 = 3'b010; s_addr = 32'h0000_0007; s_wdata = 32'd0;
    @(posedge clk); #1;
    // reset with a crossing load presented: everything must stay quiet
    v_en = 1'b1; v_dis = 1'b1;
    @(negedge clk);
    expect_eq("rst_stall", {31'd0, bus_en.stall}, 32'd0);
    expect_eq("rst_rsp_valid", {31'd0, bus_en.rsp_valid}, 32'd0);
    expect_eq("rst_mem_we", {31'd0, bus_en.mem_we}, 32'd0);
    expect_eq("rst_rdata", bus_en.rsp_rdata, 32'd0);
    expect_eq("rst_dis_rsp_valid", {31'd0, bus_dis.rsp_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; v_en = 1'b0; v_dis = 1'b0;
    @(posedge clk); #1;

    // preload memory through aligned word stores
    st_one(3'b010, 32'h0000_0010, 32'h80FF_1234, 32'h80FF_1234);
    st_one(3'b010, 32'h0000_0020, 32'h1122_3344, 32'h1122_3344);
    st_one(3'b010, 32'h0000_0004, 32'hAABB_CCDD, 32'hAABB_CCDD);
    st_one(3'b010, 32'h0000_0008, 32'h1122_3344, 32'h1122_3344);
    st_one(3'b010, 32'h0000_000C, 32'h0000_0000, 32'h0000_0000);
    st_one(3'b010, 32'h0000_0028, 32'h0000_0000, 32'h0000_0000);
    st_one(3'b010, 32'h0000_002C, 32'h0000_0000, 32'h0000_0000);
    st_one(3'b010, 32'h0000_0030, 32'h0000_0000, 32'h0000_0000);
    st_one(3'b010, 32'hFFFF_FFFC, 32'h4433_2211, 32'h4433_2211);
    st_one(3'b010, 32'h0000_0000, 32'h8877_6655, 32'h8877_6655);

    // in-word loads with sign/zero extension
    ld(1'b0, 3'b000, 32'h0000_0013, 32'hFFFF_FF80, 0);
    ld(1'b0, 3'b100, 32'h0000_0013, 32'h0000_0080, 0);
    ld(1'b0, 3'b001, 32'h0000_0012, 32'hFFFF_80FF, 0);
    ld(1'b0, 3'b101, 32'h0000_0010, 32'h0000_1234, 0);

    // sub-word stores (read-modify-write) and read back
    st_one(3'b001, 32'h0000_0022, 32'h0000_BEEF, 32'hBEEF_3344);
    ld(1'b0, 3'b010, 32'h0000_0020, 32'hBEEF_3344, 0);
    st_one(3'b000, 32'h0000_0021, 32'h0000_00A5, 32'hBEEF_A544);
    ld(1'b0, 3'b000, 32'h0000_0021, 32'hFFFF_FFA5, 0);

    // crossing loads, including address wrap past 0xFFFFFFFC
    ld(1'b0, 3'b010, 32'h0000_0007, 32'h2233_44AA, 1);
    ld(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h6655_4433, 1);

    // crossing stores, including wrap to word 0
    st_two(3'b001, 32'hFFFF_FFFF, 32'h0000_CAFE, 32'hFE33_2211, 32'h0000_0000, 32'h8877_66CA);
    ld(1'b0, 3'b010, 32'h0000_0000, 32'h8877_66CA, 0);
    ld(1'b0, 3'b010, 32'hFFFF_FFFC, 32'hFE33_2211, 0);
    st_one(3'b010, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000);
    st_two(3'b010, 32'h0000_000E, 32'hDEAD_BEEF, 32'hBEEF_0000, 32'h0000_0010, 32'h0000_DEAD);
    ld(1'b0, 3'b010, 32'h0000_000C, 32'hBEEF_0000, 0);
    ld(1'b0, 3'b010, 32'h0000_0010, 32'h0000_DEAD, 0);
    ld(1'b0, 3'b101, 32'h0000_000F, 32'h0000_ADBE, 1);
    ld(1'b0, 3'b001, 32'h0000_000F, 32'hFFFF_ADBE, 1);

    // reset during second half: first word written, second untouched
    cross_sw_cut(1'b1, 32'h0000_002E, 32'h1234_5678, 32'h5678_0000);
    ld(1'b0, 3'b010, 32'h0000_002C, 32'h5678_0000, 0);
    ld(1'b0, 3'b010, 32'h0000_0030, 32'h0000_0000, 0);

    // request dropped during second half: abort, first half stays
    cross_sw_cut(1'b0, 32'h0000_0029, 32'hCAFE_F00D, 32'hFEF0_0D00);
    ld(1'b0, 3'b010, 32'h0000_0028, 32'hFEF0_0D00, 0);
    ld(1'b0, 3'b010, 32'h0000_002C, 32'h5678_0000, 0);

    // illegal funct3 on the splitting instance
    err(1'b0, 1'b0, 3'b011, 32'h0000_0020, 1'b0, 1'b1);
    err(1'b0, 1'b1, 3'b100, 32'h0000_0020, 1'b0, 1'b1);
    err(1'b0, 1'b0, 3'b110, 32'h0000_0020, 1'b0, 1'b1);
    ld(1'b0, 3'b010, 32'h0000_0020, 32'hBEEF_A544, 0);

    // instance with splitting disabled
    err(1'b1, 1'b0, 3'b001, 32'h0000_0003, 1'b1, 1'b0);
    err(1'b1, 1'b1, 3'b010, 32'h0000_0001, 1'b1, 1'b0);
    err(1'b1, 1'b0, 3'b011, 32'h0000_0020, 1'b0, 1'b1);
    ld(1'b1, 3'b010, 32'h0000_0020, 32'hBEEF_A544, 0);
    ld(1'b1, 3'b000, 32'h0000_0003, 32'hFFFF_FF88, 0);

    @(negedge clk);
    expect_eq("rsp_queue_drained", rsp_q.size(), 32'd0);
    expect_eq("write_queue_drained", wr_q.size(), 32'd0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
